// File: rtl/pl_ddr_burst_writer.sv
// pl_ddr_burst_writer: decimating sample FIFO that drains
// into fixed-size PL DDR3 write bursts over a ring region.
module pl_ddr_burst_writer #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DECIM       = 1,
  parameter int unsigned BURST_WORDS = 256,
  parameter int unsigned FIFO_DEPTH  = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter logic [31:0] RING_BYTES  = 32'h0100_0000
) (
  input  logic                        pl_clk,
  input  logic                        pl_rst_n,
  input  logic [DATA_W-1:0]           in_data,
  input  logic                        in_valid,
  input  logic                        flush,
  input  logic                        pl_ddr_busy,
  input  logic                        pl_ddr_wr_finish,
  output logic                        pl_ddr_wr_start,
  output logic [31:0]                 pl_ddr_wr_addr,
  output logic [31:0]                 pl_ddr_wr_length,
  output logic [DATA_W-1:0]           pl_ddr_wr_data,
  output logic                        pl_ddr_wr_en,
  output logic                        burst_done,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned NW    = $clog2(BURST_WORDS) + 1;
  localparam int unsigned DCW   = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [LW-1:0]  BW_L  = LW'(BURST_WORDS);
  localparam logic [LW-1:0]  DEP_L = LW'(FIFO_DEPTH);
  localparam logic [DCW-1:0] DEC_LAST = DCW'(DECIM - 1);

  localparam logic [32:0] BURST_BYTES =
    33'(BURST_WORDS * BYTES);
  localparam logic [32:0] RING_END =
    {1'b0, BASE_ADDR} + {1'b0, RING_BYTES};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DCW-1:0]    dec_cnt;
  logic              flush_pend;
  logic              finish_q;
  logic [NW-1:0]     remain;
  logic [31:0]       next_addr;

  logic              keep;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              launch;
  logic              finish_rise;
  logic [LW-1:0]     n_sel;
  logic [32:0]       end_addr;
  logic              wrap;

  // Datapath decode: push/pop, launch test, burst size, ring wrap
  always_comb begin
    keep      = in_valid && (dec_cnt == '0);
    fifo_full = (fifo_level == DEP_L);
    push      = keep && !fifo_full;
    pop       = (state == S_DATA);
    launch    = (state == S_IDLE) && !pl_ddr_busy &&
                ((fifo_level >= BW_L) ||
                 (flush_pend && (fifo_level != '0)));
    n_sel     = (fifo_level >= BW_L) ? BW_L : fifo_level;
    finish_rise = pl_ddr_wr_finish && !finish_q;
    end_addr  = {1'b0, pl_ddr_wr_addr} +
                {1'b0, pl_ddr_wr_length};
    wrap      = (end_addr + BURST_BYTES) > RING_END;
  end

  // Write-port outputs decoded straight from the FSM state
  always_comb begin
    pl_ddr_wr_start = (state == S_START);
    pl_ddr_wr_en    = pop;
    pl_ddr_wr_data  = pop ? mem[rd_ptr] : '0;
  end

  // Decimation counter over valid samples
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n) begin
      dec_cnt <= '0;
    end else if (in_valid) begin
      if (dec_cnt == DEC_LAST)
        dec_cnt <= '0;
      else
        dec_cnt <= dec_cnt + 1'b1;
    end
  end

  // FIFO storage write port
  always_ff @(posedge pl_clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Saturating count of kept samples lost to a full FIFO
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n) begin
      drop_cnt <= '0;
    end else if (keep && fifo_full) begin
      if (drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Pending flush: held until a burst launches or FIFO drains
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n) begin
      flush_pend <= 1'b0;
    end else if (flush) begin
      flush_pend <= 1'b1;
    end else if (launch || (fifo_level == '0)) begin
      flush_pend <= 1'b0;
    end
  end

  // Finish edge detector history
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n)
      finish_q <= 1'b0;
    else
      finish_q <= pl_ddr_wr_finish;
  end

  // Burst FSM with address/length latching and ring advance
  always_ff @(posedge pl_clk) begin
    if (!pl_rst_n) begin
      state            <= S_IDLE;
      pl_ddr_wr_addr   <= '0;
      pl_ddr_wr_length <= '0;
      remain           <= '0;
      next_addr        <= BASE_ADDR;
      burst_done       <= 1'b0;
    end else begin
      burst_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (launch) begin
            state            <= S_START;
            pl_ddr_wr_addr   <= next_addr;
            pl_ddr_wr_length <= 32'(n_sel) * 32'(BYTES);
            remain           <= NW'(n_sel);
          end
        end
        S_START: begin
          state <= S_DATA;
        end
        S_DATA: begin
          remain <= remain - 1'b1;
          if (remain == NW'(1))
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (finish_rise) begin
            burst_done <= 1'b1;
            state      <= S_IDLE;
            next_addr  <= wrap ? BASE_ADDR : end_addr[31:0];
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pl_ddr_burst_writer.sv
// tb_pl_ddr_burst_writer: directed/randomised bench with a
// queue-based reference model of the burst writer.
module tb_pl_ddr_burst_writer;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DECIM  = 2;
  localparam int unsigned BW     = 4;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned BYTES  = DATA_W / 8;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] RING   = 32'd48;

  logic              pl_clk;
  logic              pl_rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              flush;
  logic              pl_ddr_busy;
  logic              pl_ddr_wr_finish;
  logic              pl_ddr_wr_start;
  logic [31:0]       pl_ddr_wr_addr;
  logic [31:0]       pl_ddr_wr_length;
  logic [DATA_W-1:0] pl_ddr_wr_data;
  logic              pl_ddr_wr_en;
  logic              burst_done;
  logic [15:0]       drop_cnt;
  logic [3:0]        fifo_level;

  pl_ddr_burst_writer #(
    .DATA_W(DATA_W), .DECIM(DECIM), .BURST_WORDS(BW),
    .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .RING_BYTES(RING)
  ) dut (
    .pl_clk(pl_clk),
    .pl_rst_n(pl_rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .flush(flush),
    .pl_ddr_busy(pl_ddr_busy),
    .pl_ddr_wr_finish(pl_ddr_wr_finish),
    .pl_ddr_wr_start(pl_ddr_wr_start),
    .pl_ddr_wr_addr(pl_ddr_wr_addr),
    .pl_ddr_wr_length(pl_ddr_wr_length),
    .pl_ddr_wr_data(pl_ddr_wr_data),
    .pl_ddr_wr_en(pl_ddr_wr_en),
    .burst_done(burst_done),
    .drop_cnt(drop_cnt),
    .fifo_level(fifo_level)
  );

  initial pl_clk = 1'b0;
  always #5 pl_clk = ~pl_clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mq[$];
  int          vcount = 0;
  int          mdrop  = 0;
  logic [31:0] maddr  = BASE;

  task automatic tick();
    @(negedge pl_clk);
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    vcount = 0;
    mdrop  = 0;
    maddr  = BASE;
  endtask

  // Drive one valid sample for the next edge and update the model
  task automatic drive_sample(input logic [31:0] d);
    in_data  = d;
    in_valid = 1'b1;
    if (vcount == 0) begin
      if (mq.size() >= DEPTH) begin
        if (mdrop < 65535) mdrop++;
      end else begin
        mq.push_back(d);
      end
    end
    vcount = (vcount + 1) % DECIM;
  endtask

  task automatic send_n(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        tick();
      end
      drive_sample($urandom);
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int bound);
    int seen;
    seen = 0;
    for (int i = 0; i < bound && seen == 0; i++) begin
      tick();
      if (pl_ddr_wr_start === 1'b1) seen = 1;
    end
    chk(tag, 64'(seen), 64'd1);
  endtask

  // Called in the START cycle; checks the full burst
  task automatic run_burst(input string tag,
                           input int n,
                           input bit feed);
    logic [31:0] expd;
    chk({tag, "_addr"}, 64'(pl_ddr_wr_addr), 64'(maddr));
    chk({tag, "_len"}, 64'(pl_ddr_wr_length), 64'(n * BYTES));
    pl_ddr_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (feed) drive_sample($urandom);
      else in_valid = 1'b0;
      tick();
      expd = (mq.size() > 0) ? mq.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_en"}, 64'(pl_ddr_wr_en), 64'd1);
      chk({tag, "_data"}, 64'(pl_ddr_wr_data), 64'(expd));
      chk({tag, "_st0"}, 64'(pl_ddr_wr_start), 64'd0);
    end
    in_valid = 1'b0;
    tick();
    chk({tag, "_en_end"}, 64'(pl_ddr_wr_en), 64'd0);
    chk({tag, "_lvl"}, 64'(fifo_level), 64'(mq.size()));
    tick();
    chk({tag, "_addr_hold"}, 64'(pl_ddr_wr_addr), 64'(maddr));
    chk({tag, "_nodone"}, 64'(burst_done), 64'd0);
    pl_ddr_wr_finish = 1'b1;
    tick();
    chk({tag, "_done"}, 64'(burst_done), 64'd1);
    pl_ddr_wr_finish = 1'b0;
    tick();
    chk({tag, "_done0"}, 64'(burst_done), 64'd0);
    maddr = maddr + 32'(n * BYTES);
    if (64'(maddr) + 64'(BW * BYTES) > 64'(BASE) + 64'(RING))
      maddr = BASE;
  endtask

  initial begin
    int r;
    int seen;
    int lvl;
    pl_rst_n         = 1'b0;
    in_data          = '0;
    in_valid         = 1'b0;
    flush            = 1'b0;
    pl_ddr_busy      = 1'b1;
    pl_ddr_wr_finish = 1'b0;
    model_reset();
    tick();
    tick();

    chk("rst_start", 64'(pl_ddr_wr_start), 64'd0);
    chk("rst_en", 64'(pl_ddr_wr_en), 64'd0);
    chk("rst_data", 64'(pl_ddr_wr_data), 64'd0);
    chk("rst_addr", 64'(pl_ddr_wr_addr), 64'd0);
    chk("rst_len", 64'(pl_ddr_wr_length), 64'd0);
    chk("rst_done", 64'(burst_done), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    chk("rst_lvl", 64'(fifo_level), 64'd0);
    pl_rst_n = 1'b1;

    send_n(2 * BW);
    chk("b1_lvl", 64'(fifo_level), 64'(mq.size()));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("busy_hold", 64'(pl_ddr_wr_start), 64'd0);
    end
    pl_ddr_busy = 1'b0;
    tick();
    chk("busy_release", 64'(pl_ddr_wr_start), 64'd1);
    run_burst("b1", BW, 1'b1);

    r = $urandom_range(0, 2);
    send_n(2 * (2 + r));
    chk("b2_lvl", 64'(fifo_level), 64'(mq.size()));
    pl_ddr_busy = 1'b0;
    wait_start("b2_start", 8);
    run_burst("b2", BW, 1'b0);

    r = $urandom_range(0, 1);
    send_n(2 * (2 - r));
    lvl = mq.size();
    chk("fl_lvl", 64'(fifo_level), 64'(lvl));
    tick();
    chk("fl_noauto", 64'(pl_ddr_wr_start), 64'd0);
    pl_ddr_busy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_start("fl_start", 8);
    run_burst("fl", lvl, 1'b0);
    chk("fl_empty", 64'(fifo_level), 64'd0);

    pl_ddr_busy = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (pl_ddr_wr_start !== 1'b0) seen++;
    end
    chk("fl2_nostart", 64'(seen), 64'd0);
    pl_ddr_busy = 1'b1;

    pl_ddr_wr_finish = 1'b1;
    tick();
    chk("fin_idle", 64'(burst_done), 64'd0);
    pl_ddr_wr_finish = 1'b0;
    tick();
    chk("fin_idle2", 64'(burst_done), 64'd0);

    send_n(2 * (DEPTH + 3));
    chk("full_lvl", 64'(fifo_level), 64'(DEPTH));
    chk("full_drop", 64'(drop_cnt), 64'(mdrop));
    chk("full_drop3", 64'(mdrop), 64'd3);

    pl_ddr_busy = 1'b0;
    tick();
    chk("wrap_start", 64'(pl_ddr_wr_start), 64'd1);
    run_burst("wrap", BW, 1'b0);

    pl_ddr_busy = 1'b0;
    tick();
    chk("mid_start", 64'(pl_ddr_wr_start), 64'd1);
    chk("mid_addr", 64'(pl_ddr_wr_addr), 64'(maddr));
    pl_ddr_busy = 1'b1;
    tick();
    chk("mid_en", 64'(pl_ddr_wr_en), 64'd1);
    chk("mid_data", 64'(pl_ddr_wr_data), 64'(mq[0]));
    pl_rst_n = 1'b0;
    tick();
    chk("mr_start", 64'(pl_ddr_wr_start), 64'd0);
    chk("mr_en", 64'(pl_ddr_wr_en), 64'd0);
    chk("mr_data", 64'(pl_ddr_wr_data), 64'd0);
    chk("mr_addr", 64'(pl_ddr_wr_addr), 64'd0);
    chk("mr_len", 64'(pl_ddr_wr_length), 64'd0);
    chk("mr_lvl", 64'(fifo_level), 64'd0);
    chk("mr_drop", 64'(drop_cnt), 64'd0);
    pl_rst_n = 1'b1;
    model_reset();
    tick();
    chk("mr_en2", 64'(pl_ddr_wr_en), 64'd0);

    send_n(2 * BW);
    pl_ddr_busy = 1'b0;
    tick();
    chk("pr_start", 64'(pl_ddr_wr_start), 64'd1);
    run_burst("pr", BW, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
